seq_shifter: RTL and testbench

Multi-cycle barrel-shift replacement for the multicycle ARM datapath. It performs LSL, LSR, ASR or ROR on a 32-bit operand, shifting one bit position per clock. It handles register-specified 8-bit shift amounts with full ARM carry-out semantics. It sits beside the ALU and is driven by the multicycle controller through a start/busy/done handshake.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_step.sv | 26 ++
 rtl/seq_shifter.sv | 104 ++++++++++
 tb/tb_seq_shifter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam int unsigned MAX_LS_ITER  = 33;
  localparam int unsigned MAX_ASR_ITER = 32;

  // Clamping the step count makes one-bit iteration reproduce ARM results
  // for amounts of 32 and above.
  function automatic logic [5:0] iter_count(input sh_type_t t, input logic [7:0] amt);
    logic [5:0] n;
    n = '0;
    case (t)
      SH_LSL, SH_LSR: n = (amt > 8'(MAX_LS_ITER))  ? 6'(MAX_LS_ITER)  : amt[5:0];
      SH_ASR:         n = (amt > 8'(MAX_ASR_ITER)) ? 6'(MAX_ASR_ITER) : amt[5:0];
      SH_ROR:         n = {1'b0, amt[4:0]};
      default:        n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step with carry-out.
module shift_step
  import shift_pkg::*;
(
  input  sh_type_t    sh_type,
  input  logic [31:0] work,
  output logic [31:0] next_work,
  output logic        c_out
);

  always_comb begin
    next_work = work;
    c_out     = work[0];
    case (sh_type)
      SH_LSL: begin
        c_out     = work[31];
        next_work = {work[30:0], 1'b0};
      end
      SH_LSR:  next_work = {1'b0, work[31:1]};
      SH_ASR:  next_work = {work[31], work[31:1]};
      SH_ROR:  next_work = {work[0], work[31:1]};
      default: next_work = work;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR unit, one bit per clock, start/busy/done handshake.
module seq_shifter
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  sh_type,
  input  logic [7:0]  sh_amt,
  input  logic [31:0] src,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  state_t      state_q, state_d;
  sh_type_t    type_q, type_d;
  logic [31:0] work_q, work_d;
  logic        c_q, c_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic [5:0]  n_iter;
  logic        ror_by_32;
  logic [31:0] step_work;
  logic        step_c;

  shift_step u_step (
    .sh_type   (type_q),
    .work      (work_q),
    .next_work (step_work),
    .c_out     (step_c)
  );

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    work_d    = work_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    cout_d    = cout_q;
    n_iter    = iter_count(sh_type_t'(sh_type), sh_amt);
    ror_by_32 = (sh_type_t'(sh_type) == SH_ROR) && (sh_amt != 8'd0) && (sh_amt[4:0] == 5'd0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = src;
          type_d = sh_type_t'(sh_type);
          c_d    = ror_by_32 ? src[31] : carry_in;
          if (n_iter == 6'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = n_iter;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step_work;
        c_d    = step_c;
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture on entry so result/carry_out are already valid while done is high.
    if (state_d == S_DONE) begin
      result_d = work_d;
      cout_d   = c_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      type_q   <= SH_LSL;
      work_q   <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      work_q   <= work_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases plus randomized ops vs an arithmetic model.
module tb_seq_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  sh_type;
  logic [7:0]  sh_amt;
  logic [31:0] src;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int tests = 0;
  int fails = 0;

  seq_shifter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sh_type   (sh_type),
    .sh_amt    (sh_amt),
    .src       (src),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ARM shifter semantics from plain arithmetic; lat is cycles from acceptance to done.
  function automatic void ref_model(input logic [1:0] t, input logic [7:0] amt,
                                    input logic [31:0] s, input logic ci,
                                    output logic [31:0] r, output logic c, output int lat);
    int a;
    int k;
    logic [63:0] w;
    a = int'(amt);
    r = s;
    c = ci;
    lat = 1;
    case (t)
      2'b00: begin
        lat = ((a > 33) ? 33 : a) + 1;
        if (a >= 1 && a <= 32) begin
          w = {32'b0, s} << a;
          r = w[31:0];
          c = w[32];
        end else if (a > 32) begin
          r = 32'h0;
          c = 1'b0;
        end
      end
      2'b01: begin
        lat = ((a > 33) ? 33 : a) + 1;
        if (a >= 1 && a <= 32) begin
          w = {s, 32'b0} >> a;
          r = w[63:32];
          c = w[31];
        end else if (a > 32) begin
          r = 32'h0;
          c = 1'b0;
        end
      end
      2'b10: begin
        lat = ((a > 32) ? 32 : a) + 1;
        if (a >= 32) begin
          r = {32{s[31]}};
          c = s[31];
        end else if (a > 0) begin
          r = $signed(s) >>> a;
          c = s[a-1];
        end
      end
      default: begin
        k = a % 32;
        lat = k + 1;
        if (a != 0) begin
          if (k == 0) begin
            c = s[31];
          end else begin
            r = (s >> k) | (s << (32 - k));
            c = r[31];
          end
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] t, input logic [7:0] amt, input logic [31:0] s,
                        input logic ci, input bit poke, input string tag);
    logic [31:0] er;
    logic        ec;
    int          elat;
    int          cyc;
    bit          seen;
    ref_model(t, amt, s, ci, er, ec, elat);
    @(negedge clk);
    sh_type  = t;
    sh_amt   = amt;
    src      = s;
    carry_in = ci;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cyc = i;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) chk({tag, "_busy_wait"}, {31'b0, busy}, 32'd1);
    end
    chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (!seen) return;
    chk({tag, "_latency"}, cyc, elat);
    chk({tag, "_result"}, result, er);
    chk({tag, "_carry"}, {31'b0, carry_out}, {31'b0, ec});
    if (poke) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk({tag, "_poke_nodone"}, {30'b0, busy, done}, 32'd0);
      end
    end else begin
      @(negedge clk);
      chk({tag, "_idle_after"}, {30'b0, busy, done}, 32'd0);
    end
    chk({tag, "_held"}, result, er);
  endtask

  initial begin
    bit extra_done;
    logic [7:0] amt_r;
    logic [7:0] picks [6];
    picks = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64};

    reset    = 1'b0;
    start    = 1'b0;
    sh_type  = 2'b00;
    sh_amt   = 8'd0;
    src      = 32'h0;
    carry_in = 1'b0;
    #12;
    chk("reset_outputs", {busy, done, carry_out}, 32'd0);
    chk("reset_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases, each also checked against the model.
    run_op(2'b00, 8'd1,   32'h8000_0001, 1'b0, 1'b0, "lsl1");
    chk("lsl1_const", result, 32'h0000_0002);
    run_op(2'b01, 8'd32,  32'h8000_0000, 1'b0, 1'b0, "lsr32");
    chk("lsr32_const", {result[30:0], carry_out}, 32'h1);
    run_op(2'b00, 8'd40,  32'hFFFF_FFFF, 1'b1, 1'b0, "lsl40");
    chk("lsl40_const", {result[30:0], carry_out}, 32'h0);
    run_op(2'b10, 8'd200, 32'h8000_0000, 1'b0, 1'b0, "asr200");
    chk("asr200_const", result, 32'hFFFF_FFFF);
    run_op(2'b11, 8'd4,   32'h0000_00F1, 1'b1, 1'b0, "ror4");
    chk("ror4_const", result, 32'h1000_000F);
    run_op(2'b11, 8'd32,  32'h8000_0000, 1'b0, 1'b0, "ror32");
    chk("ror32_carry", {31'b0, carry_out}, 32'd1);
    run_op(2'b00, 8'd0,   32'h1234_5678, 1'b1, 1'b1, "amt0");
    chk("amt0_const", {result[30:0], carry_out}, {32'h1234_5678 << 1} | 32'h1);

    // Abort mid-operation with reset.
    @(negedge clk);
    sh_type  = 2'b01;
    sh_amt   = 8'd20;
    src      = 32'hDEAD_BEEF;
    carry_in = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_flags", {busy, done, carry_out}, 32'd0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    extra_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, extra_done}, 32'd0);
    run_op(2'b00, 8'd2, 32'h0000_0001, 1'b0, 1'b0, "post_reset");
    chk("post_reset_const", result, 32'h4);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       amt_r = 8'($urandom_range(0, 40));
        1:       amt_r = 8'($urandom);
        default: amt_r = picks[$urandom_range(0, 5)];
      endcase
      run_op(2'($urandom_range(0, 3)), amt_r, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
